// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target memory: FSM state encoding,
// frame field positions on the wire and the register file depth.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_OP    = 3'd1,
    S_RX_ADDR  = 3'd2,
    S_RX_DATA  = 3'd3,
    S_STORE    = 3'd4,
    S_RD_READY = 3'd5,
    S_TX_DATA  = 3'd6
  } spi_mem_state_t;

  // Bit positions within a frame, LSB first on mosi.
  localparam int OP_BIT     = 0;
  localparam int ADDR_LSB   = 1;
  localparam int DATA_LSB   = 9;
  localparam int FRAME_W    = 17;
  localparam int RD_FRAME_W = 9;

  localparam int MEM_DEPTH  = 32;

endpackage

// File: rtl/spi_mem_if.sv
// Serial bus between the SPI controller (master) and the target memory (slave).
interface spi_mem_if;
  logic cs;
  logic mosi;
  logic miso;
  logic ready;
  logic op_done;

  modport master (output cs, output mosi, input miso, input ready, input op_done);
  modport slave  (input cs, input mosi, output miso, output ready, output op_done);
endinterface

// File: rtl/spi_mem_array.sv
// Register file: synchronous write, combinational read on the same address,
// synchronously cleared to zero by rst.
module spi_mem_array
  import spi_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int DW    = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [IW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Clear every byte on reset, otherwise commit a write when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/spi_mem.sv
// SPI target memory: deserialises op/address/data frames from cs/mosi,
// writes or reads a 32 x 8 register file, and shifts read data out on miso.
// Optional build macro: SPI_MEM_ADDR_CHK_EN -- when defined, addresses with
// any of bits [7:5] set are out of range (writes dropped, reads return 0x00).
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | wait for cs low after having seen cs high (armed)
// S_RX_OP    | sample the op bit (1 = write, 0 = read)
// S_RX_ADDR  | shift in 8 address bits, LSB first
// S_RX_DATA  | shift in 8 write data bits, LSB first
// S_STORE    | commit the write, pulse op_done
// S_RD_READY | pulse ready, load the read byte into the shift register
// S_TX_DATA  | shift 8 bits out on miso, LSB first; cs ignored
module spi_mem
  import spi_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int DW    = 8,
  parameter int AW    = 8
) (
  input logic      clk,
  input logic      rst,
  spi_mem_if.slave bus
);

  localparam int       IW       = $clog2(DEPTH);
  localparam bit [2:0] CNT_LAST = 3'd7;

  spi_mem_state_t state_q;
  logic           armed_q;
  logic           op_q;
  logic [2:0]     cnt_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  data_q;
  logic [DW-1:0]  shift_q;
  logic           miso_q;
  logic           ready_q;
  logic           op_done_q;

  logic           addr_ok;
  logic           mem_we;
  logic [DW-1:0]  mem_rdata;
  logic [DW-1:0]  rd_byte_d;

`ifdef SPI_MEM_ADDR_CHK_EN
  assign addr_ok = (addr_q[AW-1:IW] == '0);
`else
  // Upper address bits are deliberately dropped: the address aliases modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[AW-1:IW];
  assign addr_ok        = 1'b1;
`endif

  assign mem_we    = (state_q == S_STORE) && addr_ok;
  assign rd_byte_d = addr_ok ? mem_rdata : '0;

  spi_mem_array #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .IW    (IW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .addr_i  (addr_q[IW-1:0]),
    .wdata_i (data_q),
    .rdata_o (mem_rdata)
  );

  // Frame sequencing, shift registers and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b1;
      op_q      <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      shift_q   <= '0;
      miso_q    <= 1'b0;
      ready_q   <= 1'b0;
      op_done_q <= 1'b0;
    end else begin
      miso_q    <= 1'b0;
      ready_q   <= 1'b0;
      op_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // The accepting low cycle is a dead cycle; mosi is not sampled.
          if (bus.cs) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_RX_OP;
          end
        end
        S_RX_OP: begin
          if (bus.cs) begin
            state_q <= S_IDLE;
          end else begin
            op_q    <= bus.mosi;
            state_q <= S_RX_ADDR;
          end
        end
        S_RX_ADDR: begin
          if (bus.cs) begin
            state_q <= S_IDLE;
          end else begin
            addr_q <= {bus.mosi, addr_q[AW-1:1]};
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == CNT_LAST) state_q <= op_q ? S_RX_DATA : S_RD_READY;
          end
        end
        S_RX_DATA: begin
          if (bus.cs) begin
            state_q <= S_IDLE;
          end else begin
            data_q <= {bus.mosi, data_q[DW-1:1]};
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == CNT_LAST) state_q <= S_STORE;
          end
        end
        S_STORE: begin
          // Out-of-range writes are dropped by mem_we but still acknowledged.
          op_done_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        S_RD_READY: begin
          ready_q <= 1'b1;
          shift_q <= rd_byte_d;
          cnt_q   <= '0;
          state_q <= S_TX_DATA;
        end
        S_TX_DATA: begin
          miso_q  <= shift_q[0];
          shift_q <= shift_q >> 1;
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == CNT_LAST) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.miso    = miso_q;
  assign bus.ready   = ready_q;
  assign bus.op_done = op_done_q;

endmodule

// File: tb/tb_spi_mem.sv
// Self-checking bench for spi_mem. A frame-level model (byte array plus
// per-edge expected pulse/bit timelines derived from the frame edge numbers)
// is compared against ready/op_done/miso on every cycle, and read bytes
// captured from miso are checked against literal and model values.
module tb_spi_mem;
  import spi_pkg::*;

  localparam int MAXE = 40000;

  logic clk = 1'b0;
  logic rst;
  int   ecount = 0;
  bit   chk_en = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mem_m [MEM_DEPTH];
  bit exp_ready   [MAXE];
  bit exp_op_done [MAXE];
  bit exp_miso    [MAXE];

  spi_mem_if bus ();

  spi_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, ecount is the number of the last posedge.
  always @(posedge clk) ecount <= ecount + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
  endtask

  // Per-cycle comparison of all outputs against the model timelines.
  always @(negedge clk) begin
    if (chk_en && ecount < MAXE) begin
      check("ready",   {7'b0, bus.ready},   {7'b0, exp_ready[ecount]});
      check("op_done", {7'b0, bus.op_done}, {7'b0, exp_op_done[ecount]});
      check("miso",    {7'b0, bus.miso},    {7'b0, exp_miso[ecount]});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Reset takes effect at edge e: memory cleared, nothing pending from then on.
  task automatic model_reset(input int e);
    for (int i = 0; i < MEM_DEPTH; i++) mem_m[i] = 8'h00;
    for (int i = e; i < MAXE; i++) begin
      exp_ready[i]   = 1'b0;
      exp_op_done[i] = 1'b0;
      exp_miso[i]    = 1'b0;
    end
  endtask

  function automatic bit in_range(input logic [7:0] a);
`ifdef SPI_MEM_ADDR_CHK_EN
    return int'(a) < MEM_DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  // Drive a frame starting at the next edge (E0). Requires the DUT idle and armed.
  // abort_at >= 0 raises cs in place of frame bit abort_at.
  task automatic send_frame(input bit op, input logic [7:0] addr, input logic [7:0] data,
                            input int abort_at, output int e0, output bit aborted);
    logic [FRAME_W-1:0] fb;
    int nbits;
    logic [7:0] rbyte;
    fb = '0;
    fb[OP_BIT] = op;
    fb[ADDR_LSB +: 8] = addr;
    fb[DATA_LSB +: 8] = data;
    nbits = op ? FRAME_W : RD_FRAME_W;
    aborted = 1'b0;
    e0 = ecount + 1;
    bus.cs = 1'b0;
    bus.mosi = 1'($urandom_range(0, 1));
    tick();
    for (int j = 0; j < nbits; j++) begin
      if (j == abort_at) begin
        bus.cs = 1'b1;
        bus.mosi = 1'($urandom_range(0, 1));
        tick();
        aborted = 1'b1;
        break;
      end
      bus.cs = 1'b0;
      bus.mosi = fb[j];
      tick();
    end
    if (!aborted) begin
      if (op) begin
        if (in_range(addr)) mem_m[int'(addr) % MEM_DEPTH] = data;
        exp_op_done[e0 + 18] = 1'b1;
      end else begin
        rbyte = in_range(addr) ? mem_m[int'(addr) % MEM_DEPTH] : 8'h00;
        exp_ready[e0 + 10] = 1'b1;
        for (int k = 0; k < 8; k++) exp_miso[e0 + 11 + k] = rbyte[k];
      end
    end
  endtask

  // Run out the frame through E18 (cs is don't-care there), capture miso bits,
  // optionally hold cs low afterwards (must not start a frame), then re-arm.
  task automatic finish_frame(input int e0, input int keep_low, output logic [7:0] rx);
    rx = 8'h00;
    while (ecount < e0 + 18) begin
      bus.cs = 1'($urandom_range(0, 1));
      bus.mosi = 1'($urandom_range(0, 1));
      tick();
      if (ecount >= e0 + 11 && ecount <= e0 + 18) rx[ecount - e0 - 11] = bus.miso;
    end
    for (int i = 0; i < keep_low; i++) begin
      bus.cs = 1'b0;
      bus.mosi = 1'($urandom_range(0, 1));
      tick();
    end
    rearm();
  endtask

  task automatic rearm();
    int gap;
    gap = $urandom_range(1, 3);
    for (int i = 0; i < gap; i++) begin
      bus.cs = 1'b1;
      bus.mosi = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    int e0; bit ab; logic [7:0] rx;
    send_frame(1'b1, addr, data, -1, e0, ab);
    finish_frame(e0, 0, rx);
  endtask

  task automatic do_read(input logic [7:0] addr, input int keep_low, output logic [7:0] rx);
    int e0; bit ab;
    send_frame(1'b0, addr, 8'h00, -1, e0, ab);
    finish_frame(e0, keep_low, rx);
  endtask

  logic [7:0] rx;
  logic [7:0] exp_b;

  // Watchdog: the bench must always terminate.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at edge %0d", ecount);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    model_reset(0);
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Read after reset: all zero.
    do_read(8'h05, 0, rx);
    check("rd_0x05_after_reset", rx, 8'h00);

    // Write 0xA5 to 0x03, then read it back.
    do_write(8'h03, 8'hA5);
    do_read(8'h03, 0, rx);
    check("rd_0x03", rx, 8'hA5);

    // Top address, no wrap into 0x00.
    do_write(8'h1F, 8'h3C);
    do_read(8'h1F, 0, rx);
    check("rd_0x1f", rx, 8'h3C);
    do_read(8'h00, 0, rx);
    check("rd_0x00_no_wrap", rx, 8'h00);

    // Aborted write after 5 address bits leaves the old value.
    begin
      int e0; bit ab;
      do_write(8'h02, 8'h11);
      send_frame(1'b1, 8'h02, 8'hFF, 6, e0, ab);
      rearm();
      do_read(8'h02, 0, rx);
      check("rd_0x02_after_abort", rx, 8'h11);
    end

    // Out-of-range / aliasing write.
    do_write(8'h25, 8'h77);
`ifdef SPI_MEM_ADDR_CHK_EN
    exp_b = 8'h00;
`else
    exp_b = 8'h77;
`endif
    do_read(8'h05, 0, rx);
    check("rd_0x05_alias", rx, exp_b);
    do_read(8'h25, 0, rx);
    check("rd_0x25", rx, exp_b);

    // cs held low after a frame: no new frame may start until cs goes high.
    do_read(8'h03, 30, rx);
    check("rd_0x03_keep_low", rx, 8'hA5);
    do_read(8'h03, 0, rx);
    check("rd_0x03_after_unarmed", rx, 8'hA5);

    // Reset in the middle of TX_DATA.
    begin
      int e0; bit ab;
      send_frame(1'b0, 8'h03, 8'h00, -1, e0, ab);
      while (ecount < e0 + 13) begin
        bus.cs = 1'($urandom_range(0, 1));
        tick();
      end
      rst = 1'b1;
      bus.cs = 1'b1;
      model_reset(ecount + 1);
      tick();
      check("miso_after_rst",  {7'b0, bus.miso},  8'h00);
      check("ready_after_rst", {7'b0, bus.ready}, 8'h00);
      rst = 1'b0;
      tick();
      do_read(8'h03, 0, rx);
      check("rd_0x03_after_rst", rx, 8'h00);
      do_read(8'h1F, 0, rx);
      check("rd_0x1f_after_rst", rx, 8'h00);
    end

    // Randomized frames against the model.
    for (int n = 0; n < 300; n++) begin
      bit op; logic [7:0] a; logic [7:0] d; int abort_at; int e0; bit ab; int kl;
      op = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      d  = 8'($urandom);
      abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, op ? FRAME_W - 1 : RD_FRAME_W - 1) : -1;
      kl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      exp_b = in_range(a) ? mem_m[int'(a) % MEM_DEPTH] : 8'h00;
      send_frame(op, a, d, abort_at, e0, ab);
      if (ab) begin
        rearm();
      end else begin
        finish_frame(e0, kl, rx);
        if (!op) check("rand_rd_byte", rx, exp_b);
      end
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
